// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared types and defaults for the byte queue and its reader
package queue_pkg;

    // Byte width of the queue and of everything that consumes it.
    localparam int DATA_W_DEFAULT = 8;

    // Reader FSM states. The skid build only uses IDLE, POP and FIN.
    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPT,
        SEND,
        FIN
    } qr_state_t;

endpackage

// File: rtl/queue_reader_skid.sv
// rtl/queue_reader_skid.sv - 2-entry skid buffer between the queue read port and the output stream
//   Ports: clk, rst (sync, active-high, flushes both entries)
//          s_tvalid/s_tdata : byte arriving from the queue (caller keeps level+in-flight <= 2)
//          m_tvalid/m_tready/m_tdata : output stream, head entry
//          level : number of buffered bytes (0..2)
module queue_reader_skid
    import queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [1:0]        level
);

    logic [DATA_W-1:0] entry0;
    logic [DATA_W-1:0] entry1;
    logic [1:0]        lvl_q;
    logic              pop;

    assign m_tvalid = (lvl_q != 2'd0);
    assign m_tdata  = entry0;
    assign level    = lvl_q;
    assign pop      = m_tvalid && m_tready;

    // entry0 is always the head; it only changes when empty or when the
    // head is consumed, so m_tdata holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            lvl_q  <= 2'd0;
        end else begin
            case (lvl_q)
                2'd0: begin
                    if (s_tvalid) begin
                        entry0 <= s_tdata;
                        lvl_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({s_tvalid, pop})
                        2'b11:   entry0 <= s_tdata;
                        2'b01:   lvl_q  <= 2'd0;
                        2'b10: begin
                            entry1 <= s_tdata;
                            lvl_q  <= 2'd2;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    if (pop) begin
                        entry0 <= entry1;
                        if (s_tvalid) begin
                            entry1 <= s_tdata;
                        end else begin
                            lvl_q <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/queue_reader.sv
// rtl/queue_reader.sv - pops the byte queue and streams the bytes out on a valid/ready port
//   Build option: QUEUE_READER_SKID_EN selects the skid-buffered one-byte-per-cycle datapath.
//   Ports: clk, rst (sync, active-high)
//          start/burst_len : begin a burst of burst_len bytes (0 = drain until empty)
//          q_dequeue/q_data/q_is_empty : queue read side (q_data valid the cycle after a pop)
//          m_valid/m_ready/m_data : output byte stream
//          busy/done/count : burst status, done is a one-cycle pulse
module queue_reader
    import queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              q_dequeue,
    input  logic [DATA_W-1:0] q_data,
    input  logic              q_is_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    qr_state_t        state;
    qr_state_t        state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_inc;
    logic             hs;
    logic             last_beat;

    assign hs        = m_valid && m_ready;
    assign count_inc = count_q + LEN_W'(1);
    assign last_beat = (len_q != '0) && (count_inc == len_q);
    assign count     = count_q;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef QUEUE_READER_SKID_EN

    logic [1:0]       level;
    logic             inflight_q;
    logic             stop_q;
    logic [LEN_W-1:0] issued_q;
    logic [2:0]       outstanding;
    logic             issue_ok;

    queue_reader_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (inflight_q),
        .s_tdata  (q_data),
        .m_tvalid (m_valid),
        .m_tready (m_ready),
        .m_tdata  (m_data),
        .level    (level)
    );

    // Bytes that will still occupy the buffer after this cycle's handshake.
    // Counting the departing byte lets a pop issue every cycle while full-rate.
    assign outstanding = {1'b0, level} + {2'b00, inflight_q} - {2'b00, hs};

    assign issue_ok = !q_is_empty && !stop_q
                   && ((len_q == '0) || (issued_q != len_q))
                   && (outstanding < 3'd2);

    always_comb begin
        state_nxt = state;
        q_dequeue = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = POP;
            end
            POP: begin
                q_dequeue = issue_ok;
                if (len_q != '0) begin
                    if (hs && last_beat) state_nxt = FIN;
                end else if ((stop_q || q_is_empty) && (outstanding == 3'd0)) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            inflight_q <= q_dequeue;
            if (state == IDLE && start) begin
                len_q    <= burst_len;
                count_q  <= '0;
                issued_q <= '0;
                stop_q   <= 1'b0;
            end else begin
                if (q_dequeue) issued_q <= issued_q + LEN_W'(1);
                if (hs)        count_q  <= count_inc;
                // Drain ends at the first empty observation; later bytes wait for a new start.
                if (state == POP && len_q == '0 && q_is_empty) stop_q <= 1'b1;
            end
        end
    end

`else

    always_comb begin
        state_nxt = state;
        q_dequeue = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = POP;
            end
            POP: begin
                if (!q_is_empty) begin
                    q_dequeue = 1'b1;
                    state_nxt = CAPT;
                end else if (len_q == '0) begin
                    state_nxt = FIN;
                end
            end
            CAPT:    state_nxt = SEND;
            SEND: begin
                if (hs) state_nxt = last_beat ? FIN : POP;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            count_q <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                len_q   <= burst_len;
                count_q <= '0;
            end
            // q_data is the byte popped on the previous edge.
            if (state == CAPT) begin
                m_data  <= q_data;
                m_valid <= 1'b1;
            end
            if (state == SEND && hs) begin
                count_q <= count_inc;
                m_valid <= 1'b0;
            end
        end
    end

`endif

endmodule
